// File: rtl/param_fir.sv
// Stereo time-multiplexed FIR: one tap per clock, shared coefficient ROM,
// full-precision accumulation, optional rounding, saturating output stage.
module param_fir #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 1021,
  parameter int OUT_SHIFT = 15,
  parameter int ROUND     = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sequencing,
  input  logic signed [DATA_W-1:0]           lft_in,
  input  logic signed [DATA_W-1:0]           rht_in,
  output logic        [$clog2(TAPS)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]           coef_in,
  output logic signed [DATA_W-1:0]           filtered_L,
  output logic signed [DATA_W-1:0]           filtered_R,
  output logic                               out_valid,
  output logic                               abort
);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;

  // Rounding offset and saturation bounds, one bit wider than the accumulator
  // so the rounding add can never wrap.
  localparam logic signed [ACC_W:0] RND =
    (ROUND != 0 && OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << (OUT_SHIFT > 0 ? OUT_SHIFT-1 : 0)) : '0;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, DONE, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [PW-1:0]    prod_l, prod_r;
  logic                    last_tap;

  assign prod_l = PW'(coef_in) * PW'(lft_in);
  assign prod_r = PW'(coef_in) * PW'(rht_in);

  // The address wraps to 0 after issuing the last tap, so seeing 0 while in
  // MAC means this edge consumes coef[TAPS-1].
  assign last_tap = (coef_addr == '0);

  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + RND;
    t = t >>> OUT_SHIFT;
    if (t > MAXV)      scale = MAXV[DATA_W-1:0];
    else if (t < MINV) scale = MINV[DATA_W-1:0];
    else               scale = t[DATA_W-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; HOLD blocks retriggering until sequencing drops.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sequencing) state_nxt = MAC;
      MAC:     if (!sequencing) state_nxt = IDLE;
               else if (last_tap) state_nxt = DONE;
      DONE:    state_nxt = HOLD;
      HOLD:    if (!sequencing) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address sequencing, accumulation, output stage, status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l      <= '0;
      acc_r      <= '0;
      coef_addr  <= '0;
      filtered_L <= '0;
      filtered_R <= '0;
      out_valid  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      abort     <= 1'b0;
      unique case (state)
        IDLE: begin
          acc_l     <= '0;
          acc_r     <= '0;
          coef_addr <= sequencing ? AW'(1) : '0;
        end
        MAC: begin
          if (!sequencing) begin
            acc_l     <= '0;
            acc_r     <= '0;
            coef_addr <= '0;
            abort     <= 1'b1;
          end else begin
            acc_l <= acc_l + ACC_W'(prod_l);
            acc_r <= acc_r + ACC_W'(prod_r);
            if (last_tap || coef_addr == AW'(TAPS-1)) coef_addr <= '0;
            else                                      coef_addr <= coef_addr + 1'b1;
          end
        end
        DONE: begin
          filtered_L <= scale(acc_l);
          filtered_R <= scale(acc_r);
          out_valid  <= 1'b1;
          acc_l      <= '0;
          acc_r      <= '0;
        end
        HOLD: ;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/param_fir.md
PARAM_FIR -- requirements
Module: param_fir

Interface
REQ-001 Parameter DATA_W, 16, signed sample and output width.
REQ-002 Parameter COEF_W, 16, signed coefficient width.
REQ-003 Parameter TAPS, 1021, taps per run (2..4096).
REQ-004 Parameter OUT_SHIFT, 15, right shift from accumulator to output.
REQ-005 Parameter ROUND, 0: 0 truncates, 1 rounds half-up before the shift.
REQ-006 Derived constants SHALL be AW = clog2(TAPS) and ACC_W = DATA_W+COEF_W+clog2(TAPS).
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 sequencing  in  1  level; high for the whole run while the sample queue streams.
REQ-010 lft_in, rht_in  in  DATA_W each  signed left/right samples, one per cycle.
REQ-011 coef_addr  out  AW  registered address to the external coefficient ROM.
REQ-012 coef_in  in  COEF_W  signed ROM data; 1-cycle read latency.
REQ-013 filtered_L, filtered_R  out  DATA_W each  signed registered results.
REQ-014 out_valid  out  1  one-cycle pulse when new results load.
REQ-015 abort  out  1  one-cycle pulse when a run is cancelled.

Function
REQ-016 FSM states SHALL be IDLE, MAC, DONE and HOLD.
REQ-017 IDLE: coef_addr=0, both accumulators=0; sequencing=1 -> MAC with coef_addr<=1.
REQ-018 MAC, each edge: acc_L += coef_in*lft_in and acc_R += coef_in*rht_in, full-precision signed ACC_W arithmetic.
REQ-019 MAC: coef_addr SHALL increment modulo TAPS, so it reads 0 again after the last tap.
REQ-020 MAC edge k (k=1..TAPS) SHALL consume coef[k-1] and the sample present at that edge.
REQ-021 After the TAPS-th MAC edge, the FSM SHALL go to DONE.
REQ-022 DONE, one edge: compute v = acc >>> OUT_SHIFT (arithmetic), first adding 2^(OUT_SHIFT-1) if ROUND=1.
REQ-023 DONE: saturate v to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register it to filtered_L/R.
REQ-024 DONE: assert out_valid for the following cycle, then go to HOLD.
REQ-025 HOLD: wait while sequencing=1, with no retrigger; sequencing=0 -> IDLE.
REQ-026 sequencing=0 in MAC -> IDLE next edge: accumulators cleared, coef_addr=0, abort pulsed once, filtered_L/R unchanged, no out_valid.
REQ-027 filtered_L/R SHALL change only on a DONE edge or on reset.
REQ-028 Latency: out_valid SHALL be high exactly TAPS+2 cycles after the edge that samples sequencing=1 in IDLE.
REQ-029 Left and right paths SHALL share coef_in and timing and be bit-independent otherwise.

Reset
REQ-030 rst=1 SHALL force IDLE, accumulators=0, coef_addr=0, filtered_L/R=0, out_valid=0, abort=0; it overrides every state, including mid-MAC, with no abort pulse.
REQ-031 The first run SHALL start only on an edge where rst=0 and sequencing=1.

Verification (TAPS=4, OUT_SHIFT=15, DATA_W=COEF_W=16 unless stated)
REQ-032 Basic: coefs {0x4000,0x4000,0,0}, L samples {1000,2000,5,7}, R samples {-1000,-2000,0,0} -> filtered_L=1500, filtered_R=-1500, out_valid one cycle at sequencing edge +6; coef_addr sequence 1,2,3,0.
REQ-033 Saturation: coefs all 0x7FFF, samples all 0x7FFF -> filtered=0x7FFF; samples all 0x8000 -> 0x8000.
REQ-034 Rounding: ROUND=1, coef {1,0,0,0}, sample 0x4000 -> 1; ROUND=0 -> 0; sample -16384 with ROUND=0 -> -1.
REQ-035 Abort: sequencing dropped after 2 MAC edges -> abort 1 cycle, no out_valid, outputs keep prior 1500, coef_addr=0; the next full run produces the correct result.
REQ-036 Hold/reset: sequencing held 10 cycles past out_valid -> exactly one pulse. rst mid-MAC -> all outputs 0 the next cycle, no abort.
